// File: rtl/array_15_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : array_15_ctrl
//  Description : Two-requester (A/B) controller in front of a single
//                1R1W synchronous memory. Reads and writes are arbitrated
//                round-robin with independent pointers. Read data comes back
//                one cycle after the grant. An optional power-up sweep
//                (ARRAY_15_CTRL_INIT_EN) zeroes every entry before any
//                requester is admitted.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Build macro : ARRAY_15_CTRL_INIT_EN - when defined, the INIT sweep is
//                compiled in and busy is high while it runs. When undefined,
//                the controller serves requests as soon as reset is released
//                and busy is tied low.
// ----------------------------------------------------------------------------
//  Ports
//    clock, reset                 : rising-edge clock, async active-high reset
//    a_/b_rd_valid, _rd_addr      : read requests
//    a_/b_rd_ready                : read grant (valid && ready = accepted)
//    a_/b_rd_resp, _rd_data       : one-cycle response pulse and its data
//    a_/b_wr_valid, _wr_addr,
//      _wr_data, _wr_mask         : write requests (mask: 2 segments of DW/2)
//    a_/b_wr_ready                : write grant
//    mem_R0_en/addr/data          : memory read port (data one cycle later)
//    mem_W0_en/addr/data/mask     : memory write port
//    busy                         : high while the INIT sweep runs
// ============================================================================
module array_15_ctrl #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11,
    parameter int DW    = 4
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          a_rd_valid,
    input  logic [AW-1:0] a_rd_addr,
    output logic          a_rd_ready,
    output logic          a_rd_resp,
    output logic [DW-1:0] a_rd_data,

    input  logic          b_rd_valid,
    input  logic [AW-1:0] b_rd_addr,
    output logic          b_rd_ready,
    output logic          b_rd_resp,
    output logic [DW-1:0] b_rd_data,

    input  logic          a_wr_valid,
    input  logic [AW-1:0] a_wr_addr,
    input  logic [DW-1:0] a_wr_data,
    input  logic [1:0]    a_wr_mask,
    output logic          a_wr_ready,

    input  logic          b_wr_valid,
    input  logic [AW-1:0] b_wr_addr,
    input  logic [DW-1:0] b_wr_data,
    input  logic [1:0]    b_wr_mask,
    output logic          b_wr_ready,

    output logic          mem_R0_en,
    output logic [AW-1:0] mem_R0_addr,
    input  logic [DW-1:0] mem_R0_data,

    output logic          mem_W0_en,
    output logic [AW-1:0] mem_W0_addr,
    output logic [DW-1:0] mem_W0_data,
    output logic [1:0]    mem_W0_mask,

    output logic          busy
);

    // ------------------------------------------------------------------------
    // Configuration guard: the address space must be able to hold DEPTH
    // entries. Nothing is instantiated; an undersized AW simply leaves this
    // block empty in the elaborated hierarchy as a marker.
    // ------------------------------------------------------------------------
    if (DEPTH > (1 << AW)) begin : g_depth_exceeds_aw
    end

    // run_en    : requesters may be granted this cycle
    // init_act  : the sweep owns the write port this cycle
    logic          run_en;
    logic          init_act;
    logic [AW-1:0] init_cnt;

`ifdef ARRAY_15_CTRL_INIT_EN
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] init_cnt_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        case (state)
            ST_INIT: begin
                // The write of the last address happens in this cycle; RUN
                // starts on the following one.
                if (init_cnt == LAST_ADDR) begin
                    state_nxt    = ST_RUN;
                    init_cnt_nxt = '0;
                end else begin
                    init_cnt_nxt = init_cnt + 1'b1;
                end
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    // State is already INIT while reset is high, but the sweep write is
    // additionally masked so the memory is left untouched during reset.
    assign init_act = (state == ST_INIT) && !reset;
    assign run_en   = (state == ST_RUN);
    assign busy     = (state == ST_INIT);
`else
    // Without the sweep the controller is live whenever reset is low.
    assign init_act = 1'b0;
    assign init_cnt = '0;
    assign run_en   = !reset;
    assign busy     = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Round-robin arbitration. *_prio_b set means B wins a tie; it flips to
    // favour the other requester only when a grant is actually issued.
    // ------------------------------------------------------------------------
    logic rd_prio_b;
    logic wr_prio_b;
    logic a_rd_win;
    logic b_rd_win;
    logic a_wr_win;
    logic b_wr_win;

    always_comb begin
        a_rd_win = run_en && a_rd_valid && (!b_rd_valid || !rd_prio_b);
        b_rd_win = run_en && b_rd_valid && (!a_rd_valid ||  rd_prio_b);
        a_wr_win = run_en && a_wr_valid && (!b_wr_valid || !wr_prio_b);
        b_wr_win = run_en && b_wr_valid && (!a_wr_valid ||  wr_prio_b);
    end

    assign a_rd_ready = a_rd_win;
    assign b_rd_ready = b_rd_win;
    assign a_wr_ready = a_wr_win;
    assign b_wr_ready = b_wr_win;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_prio_b <= 1'b0;
            wr_prio_b <= 1'b0;
        end else begin
            if (a_rd_win) begin
                rd_prio_b <= 1'b1;
            end else if (b_rd_win) begin
                rd_prio_b <= 1'b0;
            end
            if (a_wr_win) begin
                wr_prio_b <= 1'b1;
            end else if (b_wr_win) begin
                wr_prio_b <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read path: address goes to memory in the grant cycle, the response
    // pulse is the grant delayed by one cycle, matching memory latency.
    // ------------------------------------------------------------------------
    logic a_resp_q;
    logic b_resp_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_resp_q <= 1'b0;
            b_resp_q <= 1'b0;
        end else begin
            a_resp_q <= a_rd_win;
            b_resp_q <= b_rd_win;
        end
    end

    always_comb begin
        mem_R0_en   = 1'b0;
        mem_R0_addr = '0;
        if (a_rd_win) begin
            mem_R0_en   = 1'b1;
            mem_R0_addr = a_rd_addr;
        end else if (b_rd_win) begin
            mem_R0_en   = 1'b1;
            mem_R0_addr = b_rd_addr;
        end
    end

    assign a_rd_resp = a_resp_q;
    assign b_rd_resp = b_resp_q;
    assign a_rd_data = a_resp_q ? mem_R0_data : '0;
    assign b_rd_data = b_resp_q ? mem_R0_data : '0;

    // ------------------------------------------------------------------------
    // Write path: the sweep owns the port in INIT, otherwise the write
    // winner is passed straight through. A zero mask is forwarded as-is and
    // still consumes the slot.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_W0_en   = 1'b0;
        mem_W0_addr = '0;
        mem_W0_data = '0;
        mem_W0_mask = 2'b00;
        if (init_act) begin
            mem_W0_en   = 1'b1;
            mem_W0_addr = init_cnt;
            mem_W0_mask = 2'b11;
        end else if (a_wr_win) begin
            mem_W0_en   = 1'b1;
            mem_W0_addr = a_wr_addr;
            mem_W0_data = a_wr_data;
            mem_W0_mask = a_wr_mask;
        end else if (b_wr_win) begin
            mem_W0_en   = 1'b1;
            mem_W0_addr = b_wr_addr;
            mem_W0_data = b_wr_data;
            mem_W0_mask = b_wr_mask;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_array_15_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_array_15_ctrl
//  Description : Self-checking bench for array_15_ctrl with a write-first
//                1R1W memory model and a shadow reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_array_15_ctrl;

    localparam int DEPTH = 2048;
    localparam int AW    = 11;
    localparam int DW    = 4;
    localparam int HALF  = DW / 2;
    localparam int NVEC  = 15;
`ifdef ARRAY_15_CTRL_INIT_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          a_rd_valid, b_rd_valid, a_rd_ready, b_rd_ready;
    logic [AW-1:0] a_rd_addr, b_rd_addr;
    logic          a_rd_resp, b_rd_resp;
    logic [DW-1:0] a_rd_data, b_rd_data;
    logic          a_wr_valid, b_wr_valid, a_wr_ready, b_wr_ready;
    logic [AW-1:0] a_wr_addr, b_wr_addr;
    logic [DW-1:0] a_wr_data, b_wr_data;
    logic [1:0]    a_wr_mask, b_wr_mask;
    logic          mem_R0_en;
    logic [AW-1:0] mem_R0_addr;
    logic [DW-1:0] mem_R0_data;
    logic          mem_W0_en;
    logic [AW-1:0] mem_W0_addr;
    logic [DW-1:0] mem_W0_data;
    logic [1:0]    mem_W0_mask;
    logic          busy;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    array_15_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset),
        .a_rd_valid(a_rd_valid), .a_rd_addr(a_rd_addr), .a_rd_ready(a_rd_ready),
        .a_rd_resp(a_rd_resp), .a_rd_data(a_rd_data),
        .b_rd_valid(b_rd_valid), .b_rd_addr(b_rd_addr), .b_rd_ready(b_rd_ready),
        .b_rd_resp(b_rd_resp), .b_rd_data(b_rd_data),
        .a_wr_valid(a_wr_valid), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
        .a_wr_mask(a_wr_mask), .a_wr_ready(a_wr_ready),
        .b_wr_valid(b_wr_valid), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
        .b_wr_mask(b_wr_mask), .b_wr_ready(b_wr_ready),
        .mem_R0_en(mem_R0_en), .mem_R0_addr(mem_R0_addr), .mem_R0_data(mem_R0_data),
        .mem_W0_en(mem_W0_en), .mem_W0_addr(mem_W0_addr), .mem_W0_data(mem_W0_data),
        .mem_W0_mask(mem_W0_mask), .busy(busy)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] d,
                                            input logic [1:0]    m);
        logic [DW-1:0] r;
        r = old;
        if (m[0]) r[HALF-1:0]  = d[HALF-1:0];
        if (m[1]) r[DW-1:HALF] = d[DW-1:HALF];
        return r;
    endfunction

    // Memory model: synchronous read, write-first on same-address collision.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] mem_rdata;
    logic          mem_clear;
    assign mem_R0_data = mem_rdata;

    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_W0_en)
                mem[mem_W0_addr] <= merge(mem[mem_W0_addr], mem_W0_data, mem_W0_mask);
            if (mem_R0_en)
                mem_rdata <= (mem_W0_en && mem_W0_addr == mem_R0_addr)
                           ? merge(mem[mem_W0_addr], mem_W0_data, mem_W0_mask)
                           : mem[mem_R0_addr];
        end
    end

    // Reference memory updated only from the bench's own intended writes.
    logic [DW-1:0] shadow [DEPTH];

    typedef struct packed {
        logic          arv, brv;
        logic [AW-1:0] ara, bra;
        logic          awv, bwv;
        logic [AW-1:0] awa, bwa;
        logic [DW-1:0] awd, bwd;
        logic [1:0]    awm, bwm;
        logic [3:0]    exp_rdy;   // {a_rd, b_rd, a_wr, b_wr}
    } vec_t;

    typedef struct packed {
        logic          ar, br;
        logic [DW-1:0] ad, bd;
    } rsp_t;

    vec_t vecs [NVEC];
    rsp_t sbq [$];

    function automatic vec_t mk(input logic arv, brv, input logic [AW-1:0] ara, bra,
                                input logic awv, bwv, input logic [AW-1:0] awa, bwa,
                                input logic [DW-1:0] awd, bwd, input logic [1:0] awm, bwm,
                                input logic [3:0] e);
        vec_t v;
        v = '{arv, brv, ara, bra, awv, bwv, awa, bwa, awd, bwd, awm, bwm, e};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        a_rd_valid = 0; b_rd_valid = 0; a_rd_addr = '0; b_rd_addr = '0;
        a_wr_valid = 0; b_wr_valid = 0; a_wr_addr = '0; b_wr_addr = '0;
        a_wr_data = '0; b_wr_data = '0; a_wr_mask = '0; b_wr_mask = '0;
    endtask

    task automatic check_resp();
        rsp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rd_resp", {30'd0, a_rd_resp, b_rd_resp}, {30'd0, e.ar, e.br});
            chk("a_rd_data", {28'd0, a_rd_data}, {28'd0, e.ad});
            chk("b_rd_data", {28'd0, b_rd_data}, {28'd0, e.bd});
        end
    endtask

    // Checks n consecutive sweep cycles starting in the current cycle.
    task automatic sweep_check(input int n);
        int errs;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) next_cycle();
            #3;
            if (mem_W0_en !== 1'b1 || mem_W0_addr !== AW'(i) || mem_W0_data !== '0 ||
                mem_W0_mask !== 2'b11 || busy !== 1'b1 || mem_R0_en !== 1'b0 ||
                a_rd_ready !== 1'b0 || b_rd_ready !== 1'b0) begin
                if (errs == 0)
                    $display("FAIL init_sweep: cycle %0d en=%0b addr=%0d data=%0h mask=%0b busy=%0b",
                             i, mem_W0_en, mem_W0_addr, mem_W0_data, mem_W0_mask, busy);
                errs++;
            end
        end
        chk("init_sweep_errors", errs, 0);
    endtask

    initial begin
        vecs[0]  = mk(0,0,0,0, 0,0,0,0, 4'h0,4'h0,2'b00,2'b00, 4'b0000);
        vecs[1]  = mk(0,0,0,0, 1,0,5,0, 4'hF,4'h0,2'b01,2'b00, 4'b0010);
        vecs[2]  = mk(1,0,5,0, 0,0,0,0, 4'h0,4'h0,2'b00,2'b00, 4'b1000);
        vecs[3]  = mk(1,0,9,0, 1,0,9,0, 4'hA,4'h0,2'b11,2'b00, 4'b1010);
        vecs[4]  = mk(1,1,5,9, 0,0,0,0, 4'h0,4'h0,2'b00,2'b00, 4'b0100);
        vecs[5]  = mk(1,1,5,9, 0,0,0,0, 4'h0,4'h0,2'b00,2'b00, 4'b1000);
        vecs[6]  = mk(1,1,5,9, 0,0,0,0, 4'h0,4'h0,2'b00,2'b00, 4'b0100);
        vecs[7]  = mk(1,1,5,9, 0,0,0,0, 4'h0,4'h0,2'b00,2'b00, 4'b1000);
        vecs[8]  = mk(0,0,0,0, 1,1,3,4, 4'h5,4'hC,2'b11,2'b10, 4'b0001);
        vecs[9]  = mk(0,0,0,0, 1,1,3,4, 4'h5,4'hC,2'b11,2'b10, 4'b0010);
        vecs[10] = mk(0,0,0,0, 0,1,0,3, 4'h0,4'hF,2'b00,2'b00, 4'b0001);
        vecs[11] = mk(1,1,4,3, 0,0,0,0, 4'h0,4'h0,2'b00,2'b00, 4'b0100);
        vecs[12] = mk(1,0,4,0, 0,0,0,0, 4'h0,4'h0,2'b00,2'b00, 4'b1000);
        vecs[13] = mk(1,1,7,7, 1,1,7,7, 4'h6,4'h9,2'b11,2'b11, 4'b0110);
        vecs[14] = mk(0,0,0,0, 0,0,0,0, 4'h0,4'h0,2'b00,2'b00, 4'b0000);
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

        // ---------------- reset state (requests held high) ----------------
        idle_inputs();
        reset = 1'b1;
        mem_clear = 1'b1;
        repeat (3) next_cycle();
        a_rd_valid = 1; b_wr_valid = 1;
        #3;
        chk("rst_ready", {28'd0, a_rd_ready, b_rd_ready, a_wr_ready, b_wr_ready}, 0);
        chk("rst_resp", {30'd0, a_rd_resp, b_rd_resp}, 0);
        chk("rst_mem_en", {30'd0, mem_R0_en, mem_W0_en}, 0);
        chk("rst_busy", {31'd0, busy}, {31'd0, BUSY_RST});
        next_cycle();
        idle_inputs();
        reset = 1'b0;
        mem_clear = 1'b0;

`ifdef ARRAY_15_CTRL_INIT_EN
        // Interrupt the sweep at address 1000, then let it run completely.
        a_rd_valid = 1;
        sweep_check(1000);
        next_cycle();
        #3;
        chk("sweep_addr_1000", {21'd0, mem_W0_addr}, 32'd1000);
        reset = 1'b1;
        #1;
        chk("sweep_abort_w_en", {31'd0, mem_W0_en}, 0);
        chk("sweep_abort_busy", {31'd0, busy}, 1);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        sweep_check(DEPTH);
        next_cycle();
        a_rd_valid = 0;
`endif
        #3;
        chk("busy_run", {31'd0, busy}, 0);

        // ---------------- table-driven arbitration / data vectors ----------
        for (int k = 0; k < NVEC; k++) begin
            vec_t v;
            v = vecs[k];
            next_cycle();
            a_rd_valid = v.arv; b_rd_valid = v.brv; a_rd_addr = v.ara; b_rd_addr = v.bra;
            a_wr_valid = v.awv; b_wr_valid = v.bwv; a_wr_addr = v.awa; b_wr_addr = v.bwa;
            a_wr_data = v.awd; b_wr_data = v.bwd; a_wr_mask = v.awm; b_wr_mask = v.bwm;
            #3;
            check_resp();
            chk($sformatf("ready_v%0d", k),
                {28'd0, a_rd_ready, b_rd_ready, a_wr_ready, b_wr_ready}, {28'd0, v.exp_rdy});
            chk($sformatf("w_en_v%0d", k), {31'd0, mem_W0_en}, {31'd0, v.exp_rdy[1] | v.exp_rdy[0]});
            if (v.exp_rdy[1]) shadow[v.awa] = merge(shadow[v.awa], v.awd, v.awm);
            if (v.exp_rdy[0]) shadow[v.bwa] = merge(shadow[v.bwa], v.bwd, v.bwm);
            sbq.push_back('{v.exp_rdy[3], v.exp_rdy[2],
                            v.exp_rdy[3] ? shadow[v.ara] : 4'h0,
                            v.exp_rdy[2] ? shadow[v.bra] : 4'h0});
        end

        // ---------------- in-flight read dropped by reset ------------------
        next_cycle();
        idle_inputs();
        a_rd_valid = 1; a_rd_addr = 3;
        #3;
        check_resp();
        chk("pre_rst_a_ready", {31'd0, a_rd_ready}, 1);
        sbq.push_back('{1'b1, 1'b0, shadow[3], 4'h0});
        next_cycle();
        #3;
        check_resp();
        chk("inflight_a_ready", {31'd0, a_rd_ready}, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", {30'd0, a_rd_ready, mem_R0_en}, 0);
        chk("mid_rst_w_en", {31'd0, mem_W0_en}, 0);
        chk("mid_rst_busy", {31'd0, busy}, {31'd0, BUSY_RST});
        next_cycle();
        #3;
        chk("dropped_resp", {27'd0, a_rd_resp, a_rd_data}, 0);
        next_cycle();
        reset = 1'b0;
        a_rd_valid = 1; b_rd_valid = 1; a_rd_addr = 3; b_rd_addr = 3;
`ifdef ARRAY_15_CTRL_INIT_EN
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        sweep_check(DEPTH);
        next_cycle();
`endif
        #3;
        chk("post_rst_busy", {31'd0, busy}, 0);
        chk("post_rst_prio_a", {30'd0, a_rd_ready, b_rd_ready}, 32'b10);
        sbq.push_back('{1'b1, 1'b0, shadow[3], 4'h0});
        next_cycle();
        idle_inputs();
        #3;
        check_resp();
        chk("scoreboard_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the bench cannot hang.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/array_15_ctrl.md
ARRAY_15_CTRL -- requirements
Module: array_15_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, memory entries.
REQ-002 SHALL have parameter AW, default 11, address width, log2(DEPTH).
REQ-003 SHALL have parameter DW, default 4, data width, two mask segments of DW/2 bits.
REQ-004 SHALL have port clock  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports a_rd_valid, b_rd_valid  in  1  read request per requester.
REQ-007 SHALL have ports a_rd_addr, b_rd_addr  in  AW  read address.
REQ-008 SHALL have ports a_rd_ready, b_rd_ready  out  1  read grant; accept = valid && ready.
REQ-009 SHALL have ports a_rd_resp, b_rd_resp  out  1  one-cycle pulse, read data valid.
REQ-010 SHALL have ports a_rd_data, b_rd_data  out  DW  read data, qualified by *_rd_resp.
REQ-011 SHALL have ports a_wr_valid, b_wr_valid  in  1  write request.
REQ-012 SHALL have ports a_wr_addr, b_wr_addr  in  AW; a_wr_data, b_wr_data  in  DW; a_wr_mask, b_wr_mask  in  2.
REQ-013 SHALL have ports a_wr_ready, b_wr_ready  out  1  write grant.
REQ-014 SHALL have ports mem_R0_en  out  1; mem_R0_addr  out  AW; mem_R0_data  in  DW  memory read port.
REQ-015 SHALL have ports mem_W0_en  out  1; mem_W0_addr  out  AW; mem_W0_data  out  DW; mem_W0_mask  out  2  memory write port.
REQ-016 SHALL have port busy  out  1  high while in INIT.

Function
REQ-017 SHALL implement FSM with states INIT and RUN; INIT -> RUN after write to address DEPTH-1; RUN is terminal until reset.
REQ-018 SHALL in INIT drive mem_W0_en=1, mem_W0_addr=counter (0 upward, +1 per cycle), mem_W0_data=0, mem_W0_mask=2'b11; DEPTH cycles total.
REQ-019 SHALL in INIT hold all *_ready low, mem_R0_en low, busy high.
REQ-020 SHALL in RUN arbitrate reads round-robin: sole valid requester wins; both valid -> requester not granted last read wins; read pointer updates only on a grant.
REQ-021 SHALL arbitrate writes round-robin with an independent pointer, same rules.
REQ-022 SHALL derive *_ready combinationally from valid and pointer; ready never high without its valid.
REQ-023 SHALL on read grant drive mem_R0_en=1, mem_R0_addr=winner address, same cycle.
REQ-024 SHALL assert winner *_rd_resp exactly one cycle after grant, *_rd_data=mem_R0_data that cycle; latency 1, one read per cycle throughput.
REQ-025 SHALL drive *_rd_data to 0 when corresponding *_rd_resp is low.
REQ-026 SHALL on write grant pass winner addr/data/mask to mem_W0_* with mem_W0_en=1 same cycle; mem_W0_en=0 otherwise.
REQ-027 SHALL grant a write with mask 2'b00 normally (consumes slot, memory unchanged).
REQ-028 SHALL allow read and write grants in the same cycle; same-address collision returns newly written data (memory behaviour), no controller bypass.
REQ-029 SHALL not buffer requests; ungranted requester retries by holding valid.

Reset
REQ-030 SHALL on reset: state=INIT, counter=0, both pointers favour A first, pending responses cleared.
REQ-031 SHALL hold outputs during reset: all *_ready=0, *_rd_resp=0, *_rd_data=0, mem_R0_en=0, mem_W0_en=0, busy=1 (0 without init feature).
REQ-032 SHALL on reset mid-operation abort INIT sweep or drop in-flight response, restart sweep from address 0 on release.

Configuration
REQ-033 SHALL compile INIT sweep only when macro ARRAY_15_CTRL_INIT_EN is defined.
REQ-034 SHALL without ARRAY_15_CTRL_INIT_EN enter RUN on first cycle after reset release, busy constant 0, memory contents undefined.

Verification
REQ-035 SHALL cover: reset release with ARRAY_15_CTRL_INIT_EN -> busy high 2048 cycles, writes addr 0..2047 data 0 mask 11, then readies enabled.
REQ-036 SHALL cover: A and B read valid continuously -> grants alternate A,B,A,...; each resp 1 cycle after grant.
REQ-037 SHALL cover: A writes addr 5 data 4'hF mask 01, then reads 5 -> a_rd_data=4'h3 after init.
REQ-038 SHALL cover: same-cycle write addr 9 data 4'hA mask 11 and read addr 9 -> resp data 4'hA.
REQ-039 SHALL cover: reset asserted at INIT address 1000 -> on release sweep restarts at 0, busy high full 2048 cycles.
REQ-040 SHALL cover: macro undefined -> busy 0, a_rd_ready high in first cycle after reset with a_rd_valid high.
